// File: rtl/nibble_add_seq_if.sv
// ============================================================================
// Module   : nibble_add_seq_if
// Brief    : Request, result and shared-adder signals of nibble_add_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nibble_add_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic [3:0]   add_s;
    logic         add_co;

    // Environment side: operand producer, result consumer and the 4-bit adder.
    modport master (
        output in_valid, in_a, in_b, out_ready, add_s, add_co,
        input  in_ready, out_valid, out_sum, out_co, add_a, add_b
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, add_s, add_co,
        output in_ready, out_valid, out_sum, out_co, add_a, add_b
    );
endinterface

`default_nettype wire

// File: rtl/nibble_add_seq.sv
// ============================================================================
// Module   : nibble_add_seq
// Brief    : W-bit adder sequenced over one shared 4-bit adder, LSB nibble
//            first, carry injected by a second adder pass per nibble.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_add_seq #(
    parameter int W       = 16,
    parameter int SKIP_ZC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    nibble_add_seq_if.slave bus
);
    localparam int NIB = W / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUM  = 2'd1;
    localparam logic [1:0] S_CINC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [IW-1:0] idx;
    logic          carry;
    logic          c1;
    logic [3:0]    part;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  sum_reg;
    logic          co_reg;

    logic          last;
    logic          skip;
    logic          carry_nxt;
    logic [W-1:0]  acc_upd;

    assign last = (idx == LAST_IDX);
    // With a zero incoming carry the SUM pass already yields the final nibble.
    assign skip = (SKIP_ZC != 0) && !carry;

    always_comb begin
        acc_upd              = acc;
        acc_upd[4*idx +: 4]  = bus.add_s;
        carry_nxt            = (state == S_CINC) ? (c1 | bus.add_co) : bus.add_co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.in_valid) state_nxt = S_SUM;
            S_SUM: begin
                if (skip) begin
                    state_nxt = last ? S_DONE : S_SUM;
                end else begin
                    state_nxt = S_CINC;
                end
            end
            S_CINC: state_nxt = last ? S_DONE : S_SUM;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.add_a     = 4'd0;
        bus.add_b     = 4'd0;
        case (state)
            S_IDLE: bus.in_ready = 1'b1;
            S_SUM: begin
                bus.add_a = a_reg[4*idx +: 4];
                bus.add_b = b_reg[4*idx +: 4];
            end
            S_CINC: begin
                bus.add_a = part;
                bus.add_b = {3'b000, carry};
            end
            S_DONE: bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            c1      <= 1'b0;
            part    <= 4'd0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            sum_reg <= '0;
            co_reg  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.in_a;
                        b_reg <= bus.in_b;
                        idx   <= '0;
                        carry <= 1'b0;
                        acc   <= '0;
                    end
                end
                S_SUM, S_CINC: begin
                    if (state == S_SUM && !skip) begin
                        part <= bus.add_s;
                        c1   <= bus.add_co;
                    end else begin
                        acc   <= acc_upd;
                        carry <= carry_nxt;
                        if (last) begin
                            sum_reg <= acc_upd;
                            co_reg  <= carry_nxt;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_sum = sum_reg;
    assign bus.out_co  = co_reg;
endmodule

`default_nettype wire

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Sequencer that performs W-bit additions on one shared 4-bit adder with no carry-in (add4/adder4 datapath: a, b in, s, co out).
- Splits operands into nibbles, LSB first. Injects the carry through a second adder pass per nibble.
- Valid/ready on both the request side and the result side. Sits between an operand producer and a result consumer, with the 4-bit adder instantiated beside it.

Parameters:
- W, 16, operand/result width; multiple of 4, minimum 4. NIB = W/4 is a derived localparam.
- SKIP_ZC, 0, when 1, the carry pass is skipped for any nibble whose incoming carry is 0.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request operands valid.
- in_ready  output  1  high only in IDLE.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  sum modulo 2^W.
- out_co  output  1  carry out of bit W-1.
- add_a  output  4  to shared adder input a.
- add_b  output  4  to shared adder input b.
- add_s  input  4  from shared adder sum.
- add_co  input  1  from shared adder carry out.

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async, while rst_n=0):
  - state=IDLE, out_valid=0, out_sum=0, out_co=0, add_a=add_b=0.
  - Internal carry, index and operand registers cleared.
  - in_ready=1.
  - Reset mid-operation abandons the operation; no partial result is ever presented.
- States: IDLE, SUM, CINC, DONE. Registered: idx (log2 NIB bits), carry, part (4), c1, a_reg, b_reg, acc (W).
- IDLE:
  - add_a=add_b=0.
  - On in_valid & in_ready: latch in_a/in_b, idx=0, carry=0, go to SUM.
- SUM:
  - add_a = a_reg[4*idx+:4], add_b = b_reg[4*idx+:4].
  - Default: part<=add_s, c1<=add_co, go to CINC.
  - If SKIP_ZC=1 and carry=0: acc nibble idx<=add_s, carry<=add_co, then advance.
- CINC:
  - add_a = part, add_b = {3'b0, carry}.
  - acc nibble idx<=add_s, carry<=c1|add_co, then advance.
- Advance: if idx==NIB-1, go to DONE and load out_sum<=final acc, out_co<=final carry; else idx<=idx+1, go to SUM.
- DONE:
  - out_valid=1; add_a=add_b=0.
  - out_sum/out_co stay stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- out_sum/out_co change only on the edge entering DONE; they hold the last result otherwise.
- Invariant: c1 and the CINC-pass add_co are never both 1. The bench asserts this.
- Latency, accept edge to out_valid high:
  - SKIP_ZC=0: exactly 2*NIB cycles (8 at W=16).
  - SKIP_ZC=1: NIB + (number of nibbles with incoming carry 1) cycles.
- Throughput: no new request accepted before the result handshake. The earliest next accept is the cycle after returning to IDLE.
- No combinational path from in_valid/out_ready to in_ready/out_valid. add_a/add_b are combinational from state/idx registers only.

Test Plan (W=16):
1. SKIP_ZC=0, 0x0001+0x0002 -> out_sum=0x0003, out_co=0; out_valid rises 8 cycles after accept; add_a/add_b sequence 1,2 | 3,0 | 0,0 ...
2. 0xFFFF+0x0001 -> out_sum=0x0000, out_co=1. Carry ripples through all 4 nibbles; latency 8.
3. 0x0F0F+0x00F1 -> out_sum=0x1000, out_co=0. 0x8000+0x8000 -> out_sum=0x0000, out_co=1.
4. Backpressure: out_ready=0 for 5 cycles after 0x8000+0x8000 completes -> out_valid, out_sum=0x0000 and out_co=1 held; in_ready=0. A second request held on in_valid is not accepted until the cycle after the out_ready handshake.
5. Reset mid-op: pulse rst_n low during the CINC pass of nibble 2 -> out_valid=0, in_ready=1, add_a=add_b=0 immediately. Then 0x1234+0x4321 -> out_sum=0x5555, out_co=0.
6. SKIP_ZC=1:
   - 0x1111+0x2222 -> 0x3333 with latency 4.
   - 0xFFFF+0x0001 -> 0x0000, out_co=1 with latency 7.
   - Random 1000 pairs checked against a reference (a+b), results identical to SKIP_ZC=0.
